// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle shared by N_REQ producers, the arbiter and the FIFO.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = $clog2(N_REQ)
);

  logic [N_REQ-1:0]        Req_In;
  logic [N_REQ*DATA_W-1:0] Data_In;
  logic [N_REQ-1:0]        Grant_Out;
  logic                    Accept_Out;
  logic [ID_W-1:0]         Owner_Id_Out;
  logic                    Busy_Out;
  logic                    FIFO_Full_In;
  logic                    Fifo_Write_Enable_Out;
  logic [DATA_W-1:0]       Fifo_Data_Out;

  modport master (
    input  Req_In,
    input  Data_In,
    input  FIFO_Full_In,
    output Grant_Out,
    output Accept_Out,
    output Owner_Id_Out,
    output Busy_Out,
    output Fifo_Write_Enable_Out,
    output Fifo_Data_Out
  );

  modport slave (
    output Req_In,
    output Data_In,
    output FIFO_Full_In,
    input  Grant_Out,
    input  Accept_Out,
    input  Owner_Id_Out,
    input  Busy_Out,
    input  Fifo_Write_Enable_Out,
    input  Fifo_Data_Out
  );

endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter for the FIFO write port among N_REQ producers.
// ARB_BURST_EN: grant tenure lasts up to MAX_BURST beats (else 1 beat).
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                Clk_In,
  input  logic                Reset_In,
  fifo_write_arbiter_if.master bus
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  last_d;
  logic [ID_W-1:0]  owner_q;
  logic [ID_W-1:0]  owner_d;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] grant_d;

  logic             win_vld;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;

  logic             busy;
  logic             owner_req;
  logic             accept;
  logic             last_beat;
  logic             release_g;
  logic [DATA_W-1:0] owner_data;

  // Rotating search starting just after the last winner
  always_comb begin
    win_vld = 1'b0;
    win_id  = last_q;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_REQ);
      if (!win_vld && bus.Req_In[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign busy       = (state_q == S_GRANT);
  assign owner_req  = bus.Req_In[owner_q];
  assign owner_data = bus.Data_In[owner_q*DATA_W +: DATA_W];

  assign accept = busy
                & owner_req
                & ~bus.FIFO_Full_In
                & ~Reset_In;

`ifdef ARB_BURST_EN
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign last_beat = accept
                   & (cnt_q + 4'd1 == 4'(MAX_BURST));
`else
  logic unused_cfg;

  assign unused_cfg = ^{4'(MAX_BURST)};
  assign last_beat  = accept;
`endif

  assign release_g = busy & (~owner_req | last_beat);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
`ifdef ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_GRANT;
          owner_d = win_id;
          last_d  = win_id;
`ifdef ARB_BURST_EN
          cnt_d   = 4'd0;
`endif
        end
      end
      S_GRANT: begin
        if (release_g) begin
          // Hand over in the same edge; no idle bubble
          if (win_vld) begin
            owner_d = win_id;
            last_d  = win_id;
`ifdef ARB_BURST_EN
            cnt_d   = 4'd0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept) begin
`ifdef ARB_BURST_EN
          cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    grant_d = '0;
    if (state_d == S_GRANT) begin
      grant_d[owner_d] = 1'b1;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
`ifdef ARB_BURST_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
`ifdef ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.Grant_Out             = grant_q;
  assign bus.Busy_Out              = busy;
  assign bus.Owner_Id_Out          = owner_q;
  assign bus.Accept_Out            = accept;
  assign bus.Fifo_Write_Enable_Out = accept;
  assign bus.Fifo_Data_Out         = accept ? owner_data : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter; beat data = {requester, index}.
// Expected write order comes from a beat-level round-robin model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef ARB_BURST_EN
  localparam int LIM = MB;
`else
  localparam int LIM = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  fifo_write_arbiter #(
    .N_REQ(N),
    .DATA_W(DW),
    .MAX_BURST(MB)
  ) dut (
    .Clk_In(clk),
    .Reset_In(rst),
    .bus(bus)
  );

  logic [7:0] strm [N][$];
  logic [7:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;

  logic         acc_s;
  logic [N-1:0] gnt_s;

  // Producers: pop a beat after an accepting edge, then present the next
  always begin
    logic [7:0] tmp;
    @(negedge clk);
    acc_s = bus.Accept_Out;
    gnt_s = bus.Grant_Out;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc_s && gnt_s[i] && strm[i].size() != 0)
        tmp = strm[i].pop_front();
    #1;
    for (int i = 0; i < N; i++) begin
      bus.Req_In[i] = (strm[i].size() != 0);
      bus.Data_In[i*DW +: DW] =
        (strm[i].size() != 0) ? strm[i][0] : 8'hEE;
    end
  end

  // FIFO-side monitor
  always @(negedge clk) begin : mon
    logic [7:0]   e;
    logic [N-1:0] ge;
    n_chk++;
    if (bus.Fifo_Write_Enable_Out !== bus.Accept_Out) begin
      n_fail++;
      $display("FAIL we_vs_accept: we=%b accept=%b",
               bus.Fifo_Write_Enable_Out, bus.Accept_Out);
    end
    if (bus.Fifo_Write_Enable_Out === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got %h want none",
                 bus.Fifo_Data_Out);
      end else begin
        e  = sb.pop_front();
        ge = '0;
        ge[e[5:4]] = 1'b1;
        if (bus.Fifo_Data_Out !== e
            || bus.Owner_Id_Out !== e[5:4]
            || bus.Grant_Out !== ge) begin
          n_fail++;
          $display("FAIL sb_beat: got d=%h id=%0d g=%b want d=%h id=%0d g=%b",
                   bus.Fifo_Data_Out, bus.Owner_Id_Out, bus.Grant_Out,
                   e, e[5:4], ge);
        end
      end
    end else begin
      n_chk++;
      if (bus.Fifo_Data_Out !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_data: got %h want 00", bus.Fifo_Data_Out);
      end
    end
  end

  // Load streams and push the round-robin expected write order
  task automatic plan(input int n0, input int n1,
                      input int n2, input int n3);
    int n[N];
    int rem[N];
    int last;
    int w;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    rem  = n;
    last = N - 1;
    for (int i = 0; i < N; i++)
      for (int k = 1; k <= n[i]; k++)
        strm[i].push_back(8'(i*16 + k));
    for (int g = 0; g < 64; g++) begin
      w = -1;
      for (int s = 1; s <= N; s++)
        if (w < 0 && rem[(last+s)%N] > 0) w = (last+s) % N;
      if (w < 0) break;
      for (int t = 0; t < LIM && rem[w] > 0; t++) begin
        sb.push_back(8'(w*16 + n[w] - rem[w] + 1));
        rem[w]--;
      end
      last = w;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic bit busy_q();
    bit b = 1'b0;
    for (int i = 0; i < N; i++)
      if (strm[i].size() != 0) b = 1'b1;
    return b || (sb.size() != 0);
  endfunction

  task automatic wait_drain(output bit ok);
    int c = 0;
    while (busy_q() && c < 300) begin
      @(negedge clk);
      c++;
    end
    ok = !busy_q();
    if (!ok) begin
      for (int i = 0; i < N; i++) strm[i].delete();
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_we(output bit ok);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.Fifo_Write_Enable_Out !== 1'b1 && c < 20);
    ok = (bus.Fifo_Write_Enable_Out === 1'b1);
  endtask

  task automatic wait_writes(input int n, output bit ok);
    int seen = 0;
    for (int c = 0; c < 40 && seen < n; c++) begin
      @(negedge clk);
      if (bus.Fifo_Write_Enable_Out === 1'b1) seen++;
    end
    ok = (seen == n);
  endtask

  task automatic test_reset();
    bit ok;
    plan(1, 1, 1, 1);
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({bus.Grant_Out, bus.Busy_Out, bus.Owner_Id_Out,
           bus.Accept_Out, bus.Fifo_Write_Enable_Out,
           bus.Fifo_Data_Out} !== '0) begin
        n_fail++;
        $display("FAIL reset_vals: g=%b b=%b id=%0d a=%b we=%b d=%h want 0",
                 bus.Grant_Out, bus.Busy_Out, bus.Owner_Id_Out,
                 bus.Accept_Out, bus.Fifo_Write_Enable_Out,
                 bus.Fifo_Data_Out);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.Grant_Out !== 4'b0001 || bus.Owner_Id_Out !== 2'd0
        || bus.Busy_Out !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: g=%b id=%0d b=%b want 0001 0 1",
               bus.Grant_Out, bus.Owner_Id_Out, bus.Busy_Out);
    end
    wait_drain(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_drain: got timeout want drained");
    end
  endtask

  task automatic test_single_burst();
    bit ok;
    do_reset();
    plan(0, 0, 6, 0);
    wait_we(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL burst_start: got no write want write");
    end
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.Fifo_Write_Enable_Out !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_gap: beat %0d we=%b want 1",
                 k, bus.Fifo_Write_Enable_Out);
      end
    end
    wait_drain(ok);
    n_chk++;
    if (!ok || bus.Busy_Out !== 1'b0 || bus.Grant_Out !== '0) begin
      n_fail++;
      $display("FAIL burst_end: ok=%b b=%b g=%b want 1 0 0000",
               ok, bus.Busy_Out, bus.Grant_Out);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    plan(8, 4, 0, 4);
    wait_we(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_start: got no write want write");
    end
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.Fifo_Write_Enable_Out !== 1'b1
          || bus.Grant_Out[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_stream: beat %0d we=%b g=%b want we=1 g[2]=0",
                 k, bus.Fifo_Write_Enable_Out, bus.Grant_Out);
      end
    end
    wait_drain(ok);
    n_chk++;
    if (!ok || bus.Busy_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_end: ok=%b b=%b want 1 0", ok, bus.Busy_Out);
    end
  endtask

  task automatic test_full_stall();
    bit ok;
    do_reset();
    plan(0, 4, 0, 0);
    wait_writes(2, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL full_pre: got <2 writes want 2");
    end
    @(posedge clk);
    #1 bus.FIFO_Full_In = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (bus.Fifo_Write_Enable_Out !== 1'b0
          || bus.Grant_Out !== 4'b0010
          || bus.Owner_Id_Out !== 2'd1
          || bus.Busy_Out !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold: we=%b g=%b id=%0d b=%b want 0 0010 1 1",
                 bus.Fifo_Write_Enable_Out, bus.Grant_Out,
                 bus.Owner_Id_Out, bus.Busy_Out);
      end
    end
    @(posedge clk);
    #1 bus.FIFO_Full_In = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.Fifo_Write_Enable_Out !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume: we=%b want 1",
               bus.Fifo_Write_Enable_Out);
    end
    wait_drain(ok);
    n_chk++;
    if (!ok || bus.Busy_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: ok=%b b=%b want 1 0", ok, bus.Busy_Out);
    end
  endtask

  task automatic test_early_drop();
    bit ok;
    int c = 0;
    do_reset();
    plan(1, 2, 0, 0);
    do begin
      @(negedge clk);
      c++;
    end while (bus.Grant_Out !== 4'b0010 && c < 20);
    n_chk++;
    if (bus.Grant_Out !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_handover: g=%b want 0010", bus.Grant_Out);
    end
    wait_drain(ok);
    n_chk++;
    if (!ok || bus.Busy_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_end: ok=%b b=%b want 1 0", ok, bus.Busy_Out);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    plan(0, 0, 0, 6);
    wait_writes(2, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rmid_pre: got <2 writes want 2");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.Fifo_Write_Enable_Out !== 1'b0
        || bus.Accept_Out !== 1'b0
        || bus.Grant_Out !== 4'b1000) begin
      n_fail++;
      $display("FAIL rmid_cycle: we=%b a=%b g=%b want 0 0 1000",
               bus.Fifo_Write_Enable_Out, bus.Accept_Out, bus.Grant_Out);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.Grant_Out !== 4'b0000 || bus.Busy_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_clear: g=%b b=%b want 0000 0",
               bus.Grant_Out, bus.Busy_Out);
    end
    wait_drain(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rmid_end: got timeout want drained");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    plan(4, 4, 0, 0);
    wait_we(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_start: got no write want write");
    end
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.Fifo_Write_Enable_Out !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gap: beat %0d we=%b want 1",
                 k, bus.Fifo_Write_Enable_Out);
      end
    end
    wait_drain(ok);
    n_chk++;
    if (!ok || bus.Busy_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: ok=%b b=%b want 1 0", ok, bus.Busy_Out);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.Req_In       = '0;
    bus.Data_In      = '0;
    bus.FIFO_Full_In = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_left: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
